// File: rtl/cnn_pkg.sv
// cnn_pkg: sequencer states, host setting codes and output feature-map size helpers.
package cnn_pkg;

    typedef enum logic [2:0] {IDLE, WLOAD, CONV, WB, CLEAR, DONE} seq_state_t;

    localparam logic [1:0] SET_READY = 2'b11;
    localparam logic [1:0] SET_CLEAR = 2'b00;

    function automatic int out_rows(input int img_rows, input int kernel);
        return img_rows - kernel + 1;
    endfunction

    function automatic int out_cols(input int img_cols, input int kernel);
        return img_cols - kernel + 1;
    endfunction

endpackage

// File: rtl/pixel_coord_counter.sv
// pixel_coord_counter: output-pixel row/col counter pair that saturates at the last row and wraps col per row.
module pixel_coord_counter #(
    parameter int ROWS  = 30,
    parameter int COLS  = 30,
    parameter int ROW_W = 5,
    parameter int COL_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc_col,
    input  logic             inc_row,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             row_last,
    output logic             col_last
);

    assign row_last = row == ROW_W'(ROWS - 1);
    assign col_last = col == COL_W'(COLS - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else begin
            if (inc_col) col <= col_last ? '0 : col + 1'b1;
            if (inc_row && !row_last) row <= row + 1'b1;
        end
    end

endmodule

// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: runs one CNN layer (weight load, row-by-row pixel streaming, write-back)
// once the host reports image and weights set, then clears the host status and pulses done.
module cnn_layer_sequencer import cnn_pkg::*; #(
    parameter  int IMG_ROWS = 32,
    parameter  int IMG_COLS = 32,
    parameter  int KERNEL   = 3,
    localparam int OUT_ROWS = out_rows(IMG_ROWS, KERNEL),
    localparam int OUT_COLS = out_cols(IMG_COLS, KERNEL),
    localparam int ROW_W    = OUT_ROWS > 1 ? $clog2(OUT_ROWS) : 1,
    localparam int COL_W    = OUT_COLS > 1 ? $clog2(OUT_COLS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       setting_done_condition,
    output logic             clr_write_signal,
    output logic [1:0]       clr_write_data,
    output logic             wload_req,
    input  logic             wload_ack,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [ROW_W-1:0] pix_row,
    output logic [COL_W-1:0] pix_col,
    output logic             wb_req,
    input  logic             wb_ack,
    output logic [ROW_W-1:0] wb_row,
    output logic             busy,
    output logic             layer_done
);

    seq_state_t state, state_next;
    logic clear, inc_col, inc_row, row_last, col_last;
    logic ready;

    assign ready = setting_done_condition == SET_READY;

    pixel_coord_counter #(
        .ROWS (OUT_ROWS),
        .COLS (OUT_COLS),
        .ROW_W(ROW_W),
        .COL_W(COL_W)
    ) u_ctr (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .inc_col (inc_col),
        .inc_row (inc_row),
        .row     (pix_row),
        .col     (pix_col),
        .row_last(row_last),
        .col_last(col_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        inc_col    = 1'b0;
        inc_row    = 1'b0;
        case (state)
            IDLE: begin
                clear = 1'b1;
                if (ready) state_next = WLOAD;
            end
            WLOAD: if (wload_ack) state_next = CONV;
            CONV: if (pix_ready) begin
                inc_col = 1'b1;
                if (col_last) state_next = WB;
            end
            WB: if (wb_ack) begin
                inc_row    = !row_last;
                state_next = row_last ? CLEAR : CONV;
            end
            CLEAR:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Losing the host status mid-run overrides any handshake and discards progress.
        if (!ready && state inside {WLOAD, CONV, WB}) begin
            state_next = IDLE;
            clear      = 1'b1;
            inc_col    = 1'b0;
            inc_row    = 1'b0;
        end
    end

    assign busy             = state != IDLE;
    assign wload_req        = state == WLOAD;
    assign pix_valid        = state == CONV;
    assign wb_req           = state == WB;
    assign wb_row           = pix_row;
    assign clr_write_signal = state == CLEAR;
    assign clr_write_data   = SET_CLEAR;
    assign layer_done       = state == DONE;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb_cnn_layer_sequencer: randomized scoreboard bench for a 5x5 image / 3x3 kernel layer run.
module tb_cnn_layer_sequencer;

    localparam int R = 3;
    localparam int C = 3;

    logic       clk, rst;
    logic [1:0] setting;
    logic       clr_write_signal;
    logic [1:0] clr_write_data;
    logic       wload_req, wload_ack, pix_valid, pix_ready, wb_req, wb_ack, busy, layer_done;
    logic [1:0] pix_row, pix_col, wb_row;
    logic [11:0] outs;

    cnn_layer_sequencer #(.IMG_ROWS(5), .IMG_COLS(5), .KERNEL(3)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .setting_done_condition(setting),
        .clr_write_signal      (clr_write_signal),
        .clr_write_data        (clr_write_data),
        .wload_req             (wload_req),
        .wload_ack             (wload_ack),
        .pix_valid             (pix_valid),
        .pix_ready             (pix_ready),
        .pix_row               (pix_row),
        .pix_col               (pix_col),
        .wb_req                (wb_req),
        .wb_ack                (wb_ack),
        .wb_row                (wb_row),
        .busy                  (busy),
        .layer_done            (layer_done)
    );

    assign outs = {busy, layer_done, wload_req, pix_valid, wb_req, clr_write_signal, pix_row, pix_col, wb_row};

    int checks = 0, errors = 0;
    int cyc = 0, dones = 0;
    int wl_delay = 1, wb_delay = 1, wl_cnt = 0, wb_cnt = 0;
    bit bp = 0;
    int pixq[$], wbq[$], clrq[$];

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Host image set register: the sequencer's clear write lands one cycle after CLEAR.
    always @(posedge clk) if (clr_write_signal) setting <= clr_write_data;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input int act);
        checks++;
        errors++;
        $display("FAIL %s: got %0d, expected nothing (cycle %0d)", name, act, cyc);
    endtask

    // Handshake partners: acks after a configurable number of request cycles, ready optionally random.
    always @(posedge clk) begin
        #2;
        wl_cnt    = wload_req ? wl_cnt + 1 : 0;
        wb_cnt    = wb_req ? wb_cnt + 1 : 0;
        wload_ack = wload_req && wl_cnt >= wl_delay;
        wb_ack    = wb_req && wb_cnt >= wb_delay;
        pix_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    bit pv_p, pr_p, wb_p, wa_p, wl_p, wla_p, clr_p;
    int pc_p, wr_p;

    always @(negedge clk) begin : mon
        int e;
        if (!rst) begin
            if (pix_valid && pv_p && !pr_p) chk("pix_hold", pix_row * 16 + pix_col, pc_p);
            if (wb_req && wb_p && !wa_p) begin
                chk("wb_row_hold", wb_row, wr_p);
                chk("ctr_hold_wb", pix_row * 16 + pix_col, pc_p);
            end
            if (wload_req && wl_p && !wla_p) chk("ctr_hold_wl", pix_row * 16 + pix_col, pc_p);
            if (wl_p && wla_p) chk("wload_drop", wload_req, 0);
            if (wb_p && wa_p) chk("wb_drop", wb_req, 0);
            if (pix_valid && pix_ready) begin
                if (pixq.size() == 0) unexpected("pix_extra", pix_row * 16 + pix_col);
                else begin
                    e = pixq.pop_front();
                    chk("pix_coord", pix_row * 16 + pix_col, e);
                end
            end
            if (wb_req && wb_ack) begin
                if (wbq.size() == 0) unexpected("wb_extra", wb_row);
                else begin
                    e = wbq.pop_front();
                    chk("wb_row", wb_row, e);
                end
            end
            if (clr_write_signal) begin
                chk("clr_data", clr_write_data, 0);
                chk("clr_single", clr_p, 0);
                if (clrq.size() == 0) unexpected("clr_extra", cyc);
                else begin
                    e = clrq.pop_front();
                    if (e >= 0) chk("clr_cycle", cyc, e);
                end
            end
            if (layer_done) begin
                chk("done_after_clr", clr_p, 1);
                dones++;
            end
        end
        pv_p  = pix_valid;
        pr_p  = pix_ready;
        wb_p  = wb_req;
        wa_p  = wb_ack;
        wl_p  = wload_req;
        wla_p = wload_ack;
        clr_p = clr_write_signal;
        pc_p  = pix_row * 16 + pix_col;
        wr_p  = wb_row;
    end

    // Called just after a rising edge: the request is first sampled at the next edge.
    task automatic start_run(input bit timed);
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) pixq.push_back(r * 16 + c);
            wbq.push_back(r);
        end
        clrq.push_back(timed ? cyc + 1 + wl_delay + R * (C + wb_delay) : -1);
        setting = 2'b11;
    endtask

    task automatic flush();
        pixq.delete();
        wbq.delete();
        clrq.delete();
    endtask

    task automatic wait_done(input int budget);
        int d0 = dones;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (dones > d0) break;
        end
        #2;
        chk("done_seen", int'(dones > d0), 1);
    endtask

    task automatic idle_check();
        repeat (3) @(negedge clk);
        chk("idle_after_done", busy, 0);
        @(posedge clk);
        #2;
    endtask

    initial begin
        bit bad;
        rst = 1;
        setting = 2'b00;
        #1;
        chk("reset_outs", outs, 0);
        chk("clr_data_const", clr_write_data, 0);
        repeat (3) @(posedge clk);
        #2 rst = 0;
        @(posedge clk);
        #2;

        start_run(1);
        wait_done(500);
        idle_check();

        bp = 1;
        start_run(0);
        wait_done(2000);
        idle_check();
        bp = 0;

        wl_delay = 5;
        wb_delay = 3;
        start_run(1);
        wait_done(500);
        idle_check();
        wl_delay = 1;
        wb_delay = 1;

        start_run(0);
        for (int i = 0; i < 100 && !(pix_valid && pix_row == 1); i++) @(negedge clk);
        chk("abort_at_row1", {pix_valid, pix_row}, 5);
        @(posedge clk);
        #2 setting = 2'b01;
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy", busy, 0);
        flush();
        repeat (5) @(negedge clk);
        chk("abort_stays_idle", busy, 0);
        @(posedge clk);
        #2 start_run(1);
        wait_done(500);
        idle_check();

        setting = 2'b11;
        @(posedge clk);
        #2 setting = 2'b01;
        @(negedge clk);
        chk("abort_ack_setup", {wload_req, wload_ack}, 3);
        @(negedge clk);
        chk("abort_ack_idle", {busy, pix_valid}, 0);
        repeat (3) @(negedge clk);
        setting = 2'b00;

        wb_delay = 10;
        @(posedge clk);
        #2 start_run(0);
        for (int i = 0; i < 200 && !wb_req; i++) @(negedge clk);
        chk("wb_reached", wb_req, 1);
        #3 rst = 1;
        setting = 2'b00;
        #1 chk("async_rst_outs", outs, 0);
        flush();
        @(posedge clk);
        #2 rst = 0;
        wb_delay = 1;

        for (int k = 0; k < 2; k++) begin
            bad = 0;
            setting = k ? 2'b10 : 2'b01;
            repeat (100) begin
                @(negedge clk);
                bad |= busy;
            end
            chk(k ? "hold10_idle" : "hold01_idle", bad, 0);
        end
        setting = 2'b00;
        @(posedge clk);
        #2;

        for (int k = 0; k < 6; k++) begin
            wl_delay = $urandom_range(1, 4);
            wb_delay = $urandom_range(1, 4);
            bp = k[0];
            start_run(!bp);
            wait_done(3000);
            idle_check();
        end
        bp = 0;

        chk("pixq_empty", pixq.size(), 0);
        chk("wbq_empty", wbq.size(), 0);
        chk("clrq_empty", clrq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
